// File: rtl/node_link_pkg.sv
// node_link_pkg: shared defaults for the node_link endpoint
package node_link_pkg;
  localparam int DATA_LEN_DEFAULT = 8;
  localparam int NUM_PORTS = 4;
  localparam int OVF_CNT_W = 8;
endpackage

// File: rtl/node_link_fifo.sv
// node_link_fifo: show-ahead FIFO, async active-low reset, optional write-while-full-with-pop
// Ports: din/push write side, dout/pop read side (dout is 0 when empty), full/empty status.
module node_link_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  parameter bit POP_WRITE = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  input  logic         push,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || (POP_WRITE && rd_en));
  // gated to zero so the head reads 0 after reset without clearing the array
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/node_link.sv
// node_link: paced TX to the broadcast distributor and buffered RX with overflow flag
// Ports: tx_din/tx_valid/tx_ready local send; link_dout/link_outv to distributor;
// link_din/link_inv from distributor; rx_dout/rx_valid/rx_ready local receive;
// ovf_clr/rx_overflow drop status. Define NODE_LINK_OVF_CNT_EN to add rx_ovf_cnt.
module node_link
  import node_link_pkg::*;
#(
  parameter int data_len = DATA_LEN_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter int SLOT_GAP = NUM_PORTS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [data_len-1:0]  tx_din,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [data_len-1:0]  link_dout,
  output logic                 link_outv,
  input  logic [data_len-1:0]  link_din,
  input  logic                 link_inv,
  output logic [data_len-1:0]  rx_dout,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  input  logic                 ovf_clr,
`ifdef NODE_LINK_OVF_CNT_EN
  output logic [OVF_CNT_W-1:0] rx_ovf_cnt,
`endif
  output logic                 rx_overflow
);
  localparam int GW = SLOT_GAP > 1 ? $clog2(SLOT_GAP) : 1;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_pop, drop;
  logic [data_len-1:0] tx_head;
  logic [GW-1:0] gap_cnt;
  assign tx_ready = !tx_full;
  assign rx_valid = !rx_empty;
  assign tx_pop = !tx_empty && gap_cnt == '0;
  // a full RX FIFO still takes the word when the head leaves on the same edge
  assign drop = link_inv && rx_full && !rx_ready;
  node_link_fifo #(.W(data_len), .DEPTH(FIFO_DEPTH), .POP_WRITE(1'b0)) u_tx (
    .clk(clk), .reset(reset), .din(tx_din), .push(tx_valid), .pop(tx_pop),
    .dout(tx_head), .full(tx_full), .empty(tx_empty)
  );
  node_link_fifo #(.W(data_len), .DEPTH(FIFO_DEPTH), .POP_WRITE(1'b1)) u_rx (
    .clk(clk), .reset(reset), .din(link_din), .push(link_inv), .pop(rx_ready),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      gap_cnt <= '0;
      link_outv <= 1'b0;
      link_dout <= '0;
    end else begin
      link_outv <= tx_pop;
      if (tx_pop) link_dout <= tx_head;
      gap_cnt <= tx_pop ? GW'(SLOT_GAP - 1) : (gap_cnt != '0 ? gap_cnt - GW'(1) : gap_cnt);
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) rx_overflow <= 1'b0;
    else if (drop) rx_overflow <= 1'b1;
    else if (ovf_clr) rx_overflow <= 1'b0;
`ifdef NODE_LINK_OVF_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) rx_ovf_cnt <= '0;
    else if (drop) rx_ovf_cnt <= ovf_clr ? OVF_CNT_W'(1) : (&rx_ovf_cnt ? rx_ovf_cnt : rx_ovf_cnt + OVF_CNT_W'(1));
    else if (ovf_clr) rx_ovf_cnt <= '0;
`endif
endmodule

// File: doc/node_link.md
Name: node_link

Overview:
Per-node endpoint at the far side of the 4-port broadcast distributor.
- Transmit path: queues local words and drives them to the distributor port at most once per SLOT_GAP cycles. The distributor overwrites an unserviced word, so this pacing guarantees no loss whatever its slot phase.
- Receive path: buffers the distributor's broadcast words, which have no backpressure, for a ready/valid local consumer. Overflow is flagged.

Parameters:
- data_len, 8: word width on local and link sides.
- FIFO_DEPTH, 4: entries in each of the TX and RX FIFOs. Power of two, ≥2.
- SLOT_GAP, 4: minimum cycles between link_outv pulses. Equals the distributor port count.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- tx_din  in  data_len  local word to send.
- tx_valid  in  1  tx_din valid.
- tx_ready  out  1  TX FIFO can accept.
- link_dout  out  data_len  to distributor din.
- link_outv  out  1  one-cycle valid to distributor inv.
- link_din  in  data_len  from distributor dout.
- link_inv  in  1  one-cycle valid from distributor outv.
- rx_dout  out  data_len  head of RX FIFO (show-ahead).
- rx_valid  out  1  RX FIFO non-empty.
- rx_ready  in  1  local consumer pops head.
- ovf_clr  in  1  synchronous clear of overflow status.
- rx_overflow  out  1  sticky: a broadcast word was dropped.

Behaviour:
- Reset (reset=0, async):
  - Both FIFOs are emptied and all queued words are discarded, including mid-operation.
  - link_dout=0, link_outv=0, rx_overflow=0, pacer count=0.
  - tx_ready=1, rx_valid=0, rx_dout=0.
- TX accept:
  - A word is accepted on an edge where tx_valid&&tx_ready.
  - tx_ready = !tx_full. It is derived from full only, so a push on full is refused even if a pop occurs the same cycle.
- TX pacer:
  - gap_cnt is a counter of width clog2(SLOT_GAP).
  - On an edge with TX non-empty and gap_cnt==0: pop the head into registered link_dout, set link_outv=1, load gap_cnt=SLOT_GAP-1.
  - Otherwise gap_cnt decrements if non-zero, and link_outv=0.
  - link_dout holds its last value when link_outv=0.
- TX latency: a word accepted into an idle link at edge t shows link_outv=1 after edge t+1. Back-to-back queued words are therefore spaced exactly SLOT_GAP cycles apart.
- RX write:
  - On an edge with link_inv=1, link_din is written if !rx_full, or if a pop happens on the same edge (full with simultaneous pop is accepted).
  - Otherwise the word is dropped and rx_overflow is set the next cycle.
- RX read:
  - rx_valid = !rx_empty; rx_dout = head entry.
  - The head is popped on edges where rx_valid&&rx_ready.
  - Push and pop on an empty FIFO: the word is written, and it becomes valid the next cycle.
- ovf_clr=1 clears rx_overflow on the edge. If a drop occurs on the same edge, the set wins.
- FIFO pointers are clog2(FIFO_DEPTH)+1 bits and wrap naturally.
  - full: MSBs differ, rest equal.
  - empty: pointers equal.
- No combinational path from any input to any output except the FIFO status outputs (tx_ready, rx_valid, rx_dout), which are functions of registered state only.

Optional Feature:
- Macro NODE_LINK_OVF_CNT_EN.
- When defined: adds output rx_ovf_cnt [7:0], a saturating count of dropped RX words.
  - Increments once per drop and holds at 255.
  - Reset and ovf_clr zero it; if a drop coincides with ovf_clr, the count becomes 1.
- When undefined: the port and counter do not exist, and rx_overflow behaviour is unchanged.

Decomposition:
- Package node_link_pkg holds:
  - DATA_LEN_DEFAULT=8
  - NUM_PORTS=4, the source of the SLOT_GAP default
  - OVF_CNT_W=8
- Sub-module node_link_fifo: synchronous show-ahead FIFO with async active-low reset, full/empty outputs, and a pop-while-full write-accept option. It is instantiated twice (TX, RX).

Test Plan:
1. Reset: assert reset=0 with both FIFOs non-empty and link_outv high → same cycle all outputs zero, tx_ready=1, rx_valid=0. After release, no queued word reappears.
2. TX pacing: push 0x11,0x22,0x33 at cycles 0,1,2 → link_outv=1 only in cycles 1,5,9, with link_dout=0x11,0x22,0x33 respectively.
3. TX full: tx_valid held high for 8 words 0x01..0x08 → tx_ready drops while 4 words are queued. All 8 words emerge in order, exactly 4 cycles apart, none lost or duplicated.
4. RX overflow: rx_ready=0, link_inv for 5 consecutive cycles with 0xA0..0xA4 → A4 dropped, rx_overflow=1 next cycle. Then rx_ready=1 → rx_dout A0,A1,A2,A3 on 4 consecutive cycles, then rx_valid=0.
5. RX full with simultaneous pop: full FIFO, rx_ready=1 and link_inv=1 with 0xB5 on the same edge → 0xB5 accepted as tail, rx_overflow stays 0.
6. With NODE_LINK_OVF_CNT_EN: 300 drops → rx_ovf_cnt=255. Pulse ovf_clr → rx_ovf_cnt=0 and rx_overflow=0.
